grid_serial_bridge: RTL
=======================

GRID_SERIAL_BRIDGE -- requirements
Module: grid_serial_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, memory word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, memory word width; a multiple of 8 and at least 8; BYTES = DATA_WIDTH/8.
REQ-003 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port start  input  1  one-cycle command strobe; sampled only in IDLE.
REQ-006 Port mode  input  1  0 = LOAD (serial to memory), 1 = DUMP (memory to serial); latched on accepted start.
REQ-007 Port base_addr  input  ADDR_WIDTH  first word address; latched on accepted start.
REQ-008 Port word_count  input  ADDR_WIDTH  number of words to transfer; latched on accepted start.
REQ-009 Port busy  output  1  high in every state except IDLE.
REQ-010 Port done  output  1  one-cycle pulse on command completion.
REQ-011 Port rx_data / rx_valid / rx_ready  input 8 / input 1 / output 1  inbound byte stream; a byte transfers on a cycle with rx_valid && rx_ready.
REQ-012 Port tx_data / tx_valid / tx_ready  output 8 / output 1 / input 1  outbound byte stream; a byte transfers on a cycle with tx_valid && tx_ready.
REQ-013 Port mem  memory_bus.client (ADDR_WIDTH, DATA_WIDTH)  drives address, write_data, write_enable; reads read_data.

Function
REQ-014 The memory side SHALL be treated as: write commits at the edge where write_enable=1; read_data is valid the cycle after address is presented.
REQ-015 The FSM SHALL have states IDLE, LOAD_BYTES, LOAD_WRITE, DUMP_ADDR, DUMP_WAIT, DUMP_BYTES, DONE.
REQ-016 IDLE: on start, latch mode/base_addr/word_count, clear word index i and byte index k; go to DONE if word_count==0, else LOAD_BYTES (mode 0) or DUMP_ADDR (mode 1).
REQ-017 start while busy SHALL be ignored, with no effect on the command in progress.
REQ-018 LOAD_BYTES: rx_ready=1; each accepted byte k SHALL be placed in assembly bits [8k+7:8k] (little-endian); after byte BYTES-1, go to LOAD_WRITE.
REQ-019 LOAD_WRITE (exactly one cycle): rx_ready=0, write_enable=1, address=base+i, write_data=assembled word; then i++; go to DONE if i reaches word_count, else LOAD_BYTES.
REQ-020 DUMP_ADDR (one cycle): address=base+i, write_enable=0; go to DUMP_WAIT.
REQ-021 DUMP_WAIT (one cycle): capture read_data into the shift register; go to DUMP_BYTES.
REQ-022 DUMP_BYTES: tx_valid=1, tx_data=byte k of the captured word (LSB first); tx_data SHALL hold stable until accepted; after byte BYTES-1 is accepted, i++ and go to DONE or DUMP_ADDR.
REQ-023 DONE (one cycle): done=1, busy=1; then go to IDLE.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; base+i wraps past the all-ones address to 0.
REQ-025 write_enable SHALL be 1 only in LOAD_WRITE; rx_ready SHALL be 1 only in LOAD_BYTES; tx_valid SHALL be 1 only in DUMP_BYTES.
REQ-026 In IDLE, address and write_data SHALL be 0.
REQ-027 Throughput: with rx_valid held high, LOAD SHALL take BYTES+1 cycles per word; with tx_ready held high, DUMP SHALL take BYTES+2 cycles per word.
REQ-028 Upstream stall (rx_valid=0) or downstream stall (tx_ready=0) SHALL freeze the FSM without loss or duplication of data.

Reset
REQ-029 When rst=1 at an edge, the FSM SHALL go to IDLE with busy=0, done=0, rx_ready=0, tx_valid=0, tx_data=0, write_enable=0, address=0 and write_data=0.
REQ-030 Reset mid-command SHALL discard any partial word; no memory write occurs on the reset cycle or after it.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification
REQ-032 LOAD, base=0x0010, count=2, bytes 01 02 03 04 05 06 07 08, rx_valid held -> writes 0x04030201@0x0010 and 0x08070605@0x0011, each write_enable 1 cycle; done 11 cycles after start.
REQ-033 DUMP, base=0x0010, count=2, same memory, tx_ready held -> tx bytes 01..08 in order; done pulse after the last byte; busy low the cycle after done.
REQ-034 DUMP with tx_ready toggling 1/0 every cycle -> tx_data stable while tx_ready=0; same byte order; no duplicate bytes.
REQ-035 word_count=0 with start -> no rx_ready, tx_valid or write; done high in the cycle after start.
REQ-036 LOAD, base=0xFFFF, count=2 -> writes at 0xFFFF, then 0x0000.
REQ-037 Reset after 2 bytes of a LOAD, then a new start -> no write from the first command; the new command packs from byte 0.

Source files
------------

// File: rtl/grid_serial_bridge_if.sv
// Word-wide memory port shared by the bridge and its memory.
// Ports: address/write_data/write_enable out of client, read_data in.
interface memory_bus #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  write_enable;

  modport client (
    output address,
    output write_data,
    output write_enable,
    input  read_data
  );

  modport memory (
    input  address,
    input  write_data,
    input  write_enable,
    output read_data
  );
endinterface

// File: rtl/grid_serial_bridge.sv
// Byte-stream <-> word-memory bridge: LOAD packs rx bytes into words,
// DUMP streams words out LSB first.
// Ports: clk, rst, start/mode/base_addr/word_count command, busy/done,
// rx_* inbound bytes, tx_* outbound bytes, mem client memory port.
module grid_serial_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  memory_bus.client             mem
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_BYTES,
    LOAD_WRITE,
    DUMP_ADDR,
    DUMP_WAIT,
    DUMP_BYTES,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] idx;
  logic [KW-1:0]         k;
  // Assembly register in LOAD, shift register in DUMP.
  logic [DATA_WIDTH-1:0] word;

  logic [ADDR_WIDTH-1:0] addr_cur;
  logic                  last_word;
  logic                  last_byte;

  assign addr_cur  = base + idx;
  assign last_word = (idx + ADDR_WIDTH'(1)) == count;
  assign last_byte = (k == KLAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n          = state;
    busy             = 1'b1;
    done             = 1'b0;
    rx_ready         = 1'b0;
    tx_valid         = 1'b0;
    tx_data          = 8'h00;
    mem.write_enable = 1'b0;
    mem.address      = addr_cur;
    mem.write_data   = word;
    unique case (state)
      IDLE: begin
        busy           = 1'b0;
        mem.address    = '0;
        mem.write_data = '0;
        if (start) begin
          if (word_count == '0) state_n = DONE;
          else if (mode)        state_n = DUMP_ADDR;
          else                  state_n = LOAD_BYTES;
        end
      end
      LOAD_BYTES: begin
        rx_ready = 1'b1;
        if (rx_valid && last_byte) state_n = LOAD_WRITE;
      end
      LOAD_WRITE: begin
        // A reset landing on this cycle must not commit the word.
        mem.write_enable = !rst;
        state_n = last_word ? DONE : LOAD_BYTES;
      end
      DUMP_ADDR: state_n = DUMP_WAIT;
      DUMP_WAIT: state_n = DUMP_BYTES;
      DUMP_BYTES: begin
        tx_valid = 1'b1;
        tx_data  = word[7:0];
        if (tx_ready && last_byte)
          state_n = last_word ? DONE : DUMP_ADDR;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base  <= '0;
      count <= '0;
      idx   <= '0;
      k     <= '0;
      word  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            base  <= base_addr;
            count <= word_count;
            idx   <= '0;
            k     <= '0;
            word  <= '0;
          end
        end
        LOAD_BYTES: begin
          if (rx_valid) begin
            for (int b = 0; b < BYTES; b++)
              if (k == KW'(b)) word[b*8 +: 8] <= rx_data;
            k <= last_byte ? '0 : k + KW'(1);
          end
        end
        LOAD_WRITE: idx <= idx + ADDR_WIDTH'(1);
        DUMP_WAIT: begin
          word <= mem.read_data;
          k    <= '0;
        end
        DUMP_BYTES: begin
          if (tx_ready) begin
            word <= word >> 8;
            if (last_byte) begin
              k   <= '0;
              idx <= idx + ADDR_WIDTH'(1);
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
